// File: rtl/plru_replacement_unit.sv
// Tree pseudo-LRU replacement engine: per-set PLRU bits, access updates and victim queries.
// Optional build macro PLRU_STATS_EN adds saturating update/victim/invalid-victim counters.
package pkg_line;
  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_e;
endpackage

module plru_replacement_unit #(
  parameter int N_WAY  = 8,
  parameter int N_SETS = 16,
  localparam int WAY_W = $clog2(N_WAY),
  localparam int SET_W = $clog2(N_SETS)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [SET_W-1:0]      upd_set,
  input  logic [WAY_W-1:0]      upd_way,
  input  logic                  vic_req_valid,
  output logic                  vic_req_ready,
  input  logic [SET_W-1:0]      vic_set,
  input  pkg_line::mesi_e       mesi_states [N_WAY],
  output logic                  vic_rsp_valid,
  output logic [WAY_W-1:0]      vic_way,
  output logic                  vic_from_invalid
`ifdef PLRU_STATS_EN
  ,
  output logic [31:0]           stat_upd,
  output logic [31:0]           stat_vic,
  output logic [31:0]           stat_vic_inv
`endif
);

  if (N_WAY < 2 || (N_WAY & (N_WAY - 1)) != 0) begin : g_bad_n_way
    $fatal(1, "plru_replacement_unit: N_WAY must be a power of 2 and >= 2");
  end
  if (N_SETS < 2 || (N_SETS & (N_SETS - 1)) != 0) begin : g_bad_n_sets
    $fatal(1, "plru_replacement_unit: N_SETS must be a power of 2 and >= 2");
  end

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  // Level l of the tree holds nodes (2^l - 1) .. (2^(l+1) - 2); the way prefix selects within a level.
  function automatic logic [N_WAY-2:0] plru_update(input logic [N_WAY-2:0] bits,
                                                   input logic [WAY_W-1:0] way);
    logic [N_WAY-2:0] nb;
    nb = bits;
    for (int l = 0; l < WAY_W; l++) begin
      for (int j = 0; j < (1 << l); j++) begin
        if ((way >> (WAY_W - l)) == WAY_W'(j)) begin
          nb[(1 << l) - 1 + j] = way[WAY_W-1-l];
        end
      end
    end
    return nb;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [N_WAY-2:0] bits);
    logic [WAY_W-1:0] p;
    logic             b;
    p = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int j = 0; j < (1 << l); j++) begin
        if (p == WAY_W'(j)) begin
          b = ~bits[(1 << l) - 1 + j];
        end
      end
      p = (p << 1) | WAY_W'(b);
    end
    return p;
  endfunction

  state_e             state_r, state_nxt_s;
  logic [SET_W-1:0]   cnt_r, cnt_nxt_s;
  logic [N_WAY-2:0]   plru_r [N_SETS];
  logic               upd_fire_s, vic_fire_s;
  logic [N_WAY-2:0]   upd_bits_s, q_bits_s;
  logic               inv_found_s;
  logic [WAY_W-1:0]   inv_way_s;

  assign init_done     = (state_r == ST_RUN);
  assign upd_ready     = init_done;
  assign vic_req_ready = init_done;
  assign upd_fire_s    = upd_valid && init_done;
  assign vic_fire_s    = vic_req_valid && init_done;

  // Init sweep sequencing and FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        cnt_nxt_s = cnt_r + SET_W'(1);
        if (cnt_r == SET_W'(N_SETS - 1)) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // FSM state and sweep counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_INIT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Updated bits for the accessed set; forwarded to a same-set query in the same cycle.
  always_comb begin
    upd_bits_s = plru_update(plru_r[upd_set], upd_way);
    if (upd_fire_s && (upd_set == vic_set)) begin
      q_bits_s = upd_bits_s;
    end else begin
      q_bits_s = plru_r[vic_set];
    end
  end

  // PLRU storage is cleared by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      plru_r[cnt_r] <= '0;
    end else if (upd_fire_s) begin
      plru_r[upd_set] <= upd_bits_s;
    end
  end

  // Lowest-index invalid way wins.
  always_comb begin
    inv_found_s = 1'b0;
    inv_way_s   = '0;
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (mesi_states[i] == pkg_line::MESI_I) begin
        inv_found_s = 1'b1;
        inv_way_s   = WAY_W'(i);
      end
    end
  end

  // Victim response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vic_rsp_valid    <= 1'b0;
      vic_way          <= '0;
      vic_from_invalid <= 1'b0;
    end else begin
      vic_rsp_valid <= vic_fire_s;
      if (vic_fire_s) begin
        vic_way          <= inv_found_s ? inv_way_s : plru_victim(q_bits_s);
        vic_from_invalid <= inv_found_s;
      end
    end
  end

`ifdef PLRU_STATS_EN
  // Saturating activity counters, held at zero until the sweep finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_upd     <= 32'd0;
      stat_vic     <= 32'd0;
      stat_vic_inv <= 32'd0;
    end else if (!init_done) begin
      stat_upd     <= 32'd0;
      stat_vic     <= 32'd0;
      stat_vic_inv <= 32'd0;
    end else begin
      if (upd_fire_s && stat_upd != 32'hFFFF_FFFF) stat_upd <= stat_upd + 32'd1;
      if (vic_fire_s && stat_vic != 32'hFFFF_FFFF) stat_vic <= stat_vic + 32'd1;
      if (vic_fire_s && inv_found_s && stat_vic_inv != 32'hFFFF_FFFF) begin
        stat_vic_inv <= stat_vic_inv + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_plru_replacement_unit.sv
// Directed bench for plru_replacement_unit (N_WAY=8, N_SETS=16) with hand-computed victims.
module tb_plru_replacement_unit;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 init_done, upd_ready, vic_req_ready;
  logic                 upd_valid, vic_req_valid;
  logic [3:0]           upd_set, vic_set;
  logic [2:0]           upd_way;
  pkg_line::mesi_e      mesi_states [8];
  logic                 vic_rsp_valid, vic_from_invalid;
  logic [2:0]           vic_way;
`ifdef PLRU_STATS_EN
  logic [31:0]          stat_upd, stat_vic, stat_vic_inv;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int exp_upd  = 0;
  int exp_vic  = 0;
  int exp_inv  = 0;

  logic [3:0] b2b_set [4];
  logic [2:0] b2b_way [4];

  always #5 clk = ~clk;

  plru_replacement_unit #(.N_WAY(8), .N_SETS(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .init_done        (init_done),
    .upd_valid        (upd_valid),
    .upd_ready        (upd_ready),
    .upd_set          (upd_set),
    .upd_way          (upd_way),
    .vic_req_valid    (vic_req_valid),
    .vic_req_ready    (vic_req_ready),
    .vic_set          (vic_set),
    .mesi_states      (mesi_states),
    .vic_rsp_valid    (vic_rsp_valid),
    .vic_way          (vic_way),
    .vic_from_invalid (vic_from_invalid)
`ifdef PLRU_STATS_EN
    ,
    .stat_upd         (stat_upd),
    .stat_vic         (stat_vic),
    .stat_vic_inv     (stat_vic_inv)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mesi(input logic [7:0] inv_mask);
    for (int i = 0; i < 8; i++) mesi_states[i] = inv_mask[i] ? pkg_line::MESI_I : pkg_line::MESI_M;
  endtask

  task automatic check_stats(input string tag);
`ifdef PLRU_STATS_EN
    check({tag, "_stat_upd"}, stat_upd, exp_upd);
    check({tag, "_stat_vic"}, stat_vic, exp_vic);
    check({tag, "_stat_inv"}, stat_vic_inv, exp_inv);
`endif
  endtask

  task automatic do_update(input logic [3:0] s, input logic [2:0] w);
    @(negedge clk);
    upd_valid = 1'b1; upd_set = s; upd_way = w;
    @(negedge clk);
    upd_valid = 1'b0;
    exp_upd++;
  endtask

  task automatic do_query(input string tag, input logic [3:0] s, input logic [7:0] inv_mask,
                          input logic [2:0] exp_way, input logic exp_inv_flag);
    @(negedge clk);
    vic_req_valid = 1'b1; vic_set = s; set_mesi(inv_mask);
    @(posedge clk); #1;
    check({tag, "_rsp"}, vic_rsp_valid, 1'b1);
    check({tag, "_way"}, vic_way, exp_way);
    check({tag, "_inv"}, vic_from_invalid, exp_inv_flag);
    @(negedge clk);
    vic_req_valid = 1'b0; set_mesi(8'h00);
    @(posedge clk); #1;
    check({tag, "_rsp_drop"}, vic_rsp_valid, 1'b0);
    exp_vic++;
    if (exp_inv_flag) exp_inv++;
  endtask

  initial begin
    rst = 1'b1;
    upd_valid = 1'b0; upd_set = 4'd0; upd_way = 3'd0;
    vic_req_valid = 1'b0; vic_set = 4'd0;
    set_mesi(8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_init_done", init_done, 1'b0);
    check("rst_upd_ready", upd_ready, 1'b0);
    check("rst_rsp_valid", vic_rsp_valid, 1'b0);
    check("rst_vic_way", vic_way, 3'd0);
    check("rst_vic_inv", vic_from_invalid, 1'b0);
    check_stats("rst");

    // Test 1: exactly 16 init cycles, then all-zero bits pick way 7
    @(negedge clk); rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      check("init_done_sweep", init_done, (i == 16) ? 1'b1 : 1'b0);
    end
    check("upd_ready_run", upd_ready, 1'b1);
    check("vic_ready_run", vic_req_ready, 1'b1);
    do_query("t1_set3", 4'd3, 8'h00, 3'd7, 1'b0);

    // Test 2: touching way 7 steers the victim to way 3; set 4 unaffected
    do_update(4'd3, 3'd7);
    do_query("t2_set3", 4'd3, 8'h00, 3'd3, 1'b0);
    do_query("t2_set4", 4'd4, 8'h00, 3'd7, 1'b0);

    // Test 3: invalid ways take priority and the query leaves the bits alone
    do_query("t3_inv", 4'd3, 8'h24, 3'd2, 1'b1);
    do_query("t3_after", 4'd3, 8'h00, 3'd3, 1'b0);
    do_query("t3_inv7", 4'd4, 8'h80, 3'd7, 1'b1);

    // Test 4: same-cycle update and query of set 3 uses forwarded bits
    @(negedge clk);
    upd_valid = 1'b1; upd_set = 4'd3; upd_way = 3'd3;
    vic_req_valid = 1'b1; vic_set = 4'd3;
    @(posedge clk); #1;
    check("t4_fwd_rsp", vic_rsp_valid, 1'b1);
    check("t4_fwd_way", vic_way, 3'd5);
    @(negedge clk);
    upd_valid = 1'b0; vic_req_valid = 1'b0;
    exp_upd++; exp_vic++;
    do_query("t4_stored", 4'd3, 8'h00, 3'd5, 1'b0);

    // Same cycle, different sets: independent
    @(negedge clk);
    upd_valid = 1'b1; upd_set = 4'd5; upd_way = 3'd7;
    vic_req_valid = 1'b1; vic_set = 4'd6;
    @(posedge clk); #1;
    check("t4_indep_way", vic_way, 3'd7);
    @(negedge clk);
    upd_valid = 1'b0; vic_req_valid = 1'b0;
    exp_upd++; exp_vic++;
    do_query("t4_set5", 4'd5, 8'h00, 3'd3, 1'b0);

    // Test 5: back-to-back updates of every way in set 0 leave way 0 as LRU
    @(negedge clk);
    upd_valid = 1'b1; upd_set = 4'd0;
    for (int w = 0; w < 8; w++) begin
      upd_way = 3'(w);
      @(negedge clk);
      exp_upd++;
    end
    upd_valid = 1'b0;
    do_query("t5_set0", 4'd0, 8'h00, 3'd0, 1'b0);

    b2b_set[0] = 4'd3; b2b_way[0] = 3'd5;
    b2b_set[1] = 4'd4; b2b_way[1] = 3'd7;
    b2b_set[2] = 4'd5; b2b_way[2] = 3'd3;
    b2b_set[3] = 4'd0; b2b_way[3] = 3'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vic_req_valid = 1'b1; vic_set = b2b_set[k];
      @(posedge clk); #1;
      check("t5_b2b_rsp", vic_rsp_valid, 1'b1);
      check("t5_b2b_way", vic_way, b2b_way[k]);
      exp_vic++;
    end
    @(negedge clk); vic_req_valid = 1'b0;
    @(posedge clk); #1;
    check("t5_b2b_end", vic_rsp_valid, 1'b0);
    check_stats("t5");

    // Test 6: reset right after an accepted query kills the response and re-runs init
    @(negedge clk);
    vic_req_valid = 1'b1; vic_set = 4'd3;
    @(posedge clk); #1;
    rst = 1'b1; vic_req_valid = 1'b0;
    #1;
    check("t6_rst_rsp", vic_rsp_valid, 1'b0);
    check("t6_rst_way", vic_way, 3'd0);
    check("t6_rst_done", init_done, 1'b0);
    exp_upd = 0; exp_vic = 0; exp_inv = 0;
    check_stats("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    vic_req_valid = 1'b1; vic_set = 4'd3;
    upd_valid = 1'b1; upd_set = 4'd3; upd_way = 3'd7;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      check("t6_init_rsp", vic_rsp_valid, 1'b0);
      check("t6_init_done", init_done, (i == 16) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    vic_req_valid = 1'b0; upd_valid = 1'b0;
    check_stats("t6_init");
    do_query("t6_set3", 4'd3, 8'h00, 3'd7, 1'b0);
    check_stats("t6_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
